nios2_port_gpio: RTL and testbench
==================================

// Module: nios2_port_gpio
// PURPOSE
//  Parametrised Avalon-MM PIO, successor to the fixed 8-bit LED output port. Per-bit direction,
//  atomic set/clear, synchronised inputs with edge capture and masked IRQ, hardware LED blink.
//  Sits on the Nios II data master as a zero-wait-state slave.
// PARAMETERS
//  WIDTH       8   port width in bits, 1..32
//  OUT_RESET   0   reset value of the DATA output register (WIDTH bits)
//  DIR_RESET   '1  reset value of DIRECTION; 1 = bit drives output
//  EDGE_TYPE   0   capture mode: 0 rising, 1 falling, 2 any edge
//  SYNC_STAGES 2   input synchroniser depth, 2..3
//  PRESC_W     24  blink prescaler width in bits, 1..32
// PORTS
//  clk        in   1      system clock
//  reset_n    in   1      asynchronous active-low reset
//  address    in   3      register select, word offsets 0..7
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe
//  writedata  in   32     write data; bits above WIDTH/PRESC_W ignored
//  readdata   out  32     read data, combinational (read latency 0), zero-extended
//  in_port    in   WIDTH  asynchronous external inputs
//  out_port   out  WIDTH  output value, after blink
//  oe         out  WIDTH  output enable, = DIRECTION
//  irq        out  1      level interrupt, = |(EDGECAP & IRQMASK)
// BEHAVIOUR
//  Write = chipselect & ~write_n, sampled on posedge clk. Register map (R/W unless noted):
//   0 DATA    W: data_out<=wd. R: bit i = DIR[i] ? data_out[i] : in_sync[i]
//   1 DIR     per-bit direction
//   2 IRQMASK per-bit interrupt enable
//   3 EDGECAP R: captured edges. W: write-1-to-clear
//   4 OUTSET  W: data_out |= wd. R: 0
//   5 OUTCLR  W: data_out &= ~wd. R: 0
//   6 BLINKEN per-bit blink enable
//   7 PERIOD  blink half-period in clk cycles minus 1 (PRESC_W bits)
//  Reset: data_out=OUT_RESET, DIR=DIR_RESET, IRQMASK=0, EDGECAP=0, BLINKEN=0, PERIOD=0,
//   prescaler=0, phase=0, sync chain and prev=0. So out_port=OUT_RESET, oe=DIR_RESET, irq=0.
//  Synchroniser: in_port passes SYNC_STAGES flops -> in_sync; prev <= in_sync each cycle.
//   edge[i] = rise/fall/any per EDGE_TYPE from prev/in_sync, gated by ~DIR[i].
//   Pin change -> EDGECAP set SYNC_STAGES+1 cycles later; irq same cycle as EDGECAP (comb).
//  EDGECAP[i] next = (EDGECAP[i] & ~clr[i]) | edge[i]; simultaneous clear and new edge: set wins.
//  Blink: PERIOD==0 -> prescaler held 0, phase held 0. Else prescaler counts down; at 0 reloads
//   PERIOD and toggles phase (one toggle per PERIOD+1 cycles). Write to PERIOD: prescaler<=new
//   value, phase<=0 same edge. out_port = data_out ^ (BLINKEN & {WIDTH{phase}}), registered
//   sources only, no comb path from bus.
//  Width: writes truncate to WIDTH; reads zero-fill bits 31:WIDTH. Addresses unused: none.
//  DIR change mid-run: edge gating applies from next cycle; EDGECAP contents retained.
//  Reset assertion mid-operation clears all state immediately (async); deassertion is
//   synchronised externally.
// STRUCTURE
//  Package nios2_port_pkg: register offset localparams (ADDR_DATA..ADDR_PERIOD),
//   EDGE_RISE/EDGE_FALL/EDGE_ANY constants.
//  Sub-module nios2_port_sync: WIDTH-wide synchroniser + prev flop + edge detect, params
//   WIDTH, SYNC_STAGES, EDGE_TYPE; outputs in_sync, edge. Register file, blink in top.
// TESTING
//  1 Reset, WIDTH=8, OUT_RESET=8'hA5: out_port=A5, oe=FF, irq=0; read addr0 -> 32'h000000A5.
//  2 Write DATA=0F, OUTSET=30, OUTCLR=03: out_port=3C; reads of addr4/5 return 0.
//  3 DIR=F0, IRQMASK=01, in_port[0] 0->1 (EDGE_TYPE=0): EDGECAP=01 and irq=1 exactly 3 cycles
//    later; write EDGECAP=01 -> irq=0 next cycle; falling edge produces no capture.
//  4 Clear EDGECAP bit 0 in same cycle as new rising edge on bit 0: EDGECAP[0] stays 1.
//  5 DATA=00, BLINKEN=81, PERIOD=3: out_port toggles 00<->81 every 4 cycles; write PERIOD=0
//    -> out_port=00 next cycle and stays.
//  6 Assert reset_n mid-blink with EDGECAP nonzero: all outputs at reset values asynchronously.

Source files
------------

// File: rtl/nios2_port_pkg.sv
// Shared constants for the Nios II GPIO port: register word offsets and edge-capture modes.
package nios2_port_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam logic [2:0] ADDR_BLINKEN = 3'd6;
  localparam logic [2:0] ADDR_PERIOD  = 3'd7;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/nios2_port_sync.sv
// Input synchroniser chain plus previous-value flop; flags selected edges on input-direction bits.
// Latency: in_sync lags in_port by SYNC_STAGES cycles, edge_hit is combinational from in_sync/prev.
module nios2_port_sync
  import nios2_port_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  input  logic [WIDTH-1:0] dir,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_hit
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] det;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      prev <= '0;
    end else begin
      stage[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      prev <= stage[SYNC_STAGES-1];
    end
  end

  assign in_sync = stage[SYNC_STAGES-1];

  always_comb begin
    det = in_sync & ~prev;
    case (EDGE_TYPE)
      EDGE_FALL: det = prev & ~in_sync;
      EDGE_ANY:  det = prev ^ in_sync;
      default:   det = in_sync & ~prev;
    endcase
    // Bits currently driven as outputs never capture edges.
    edge_hit = det & ~dir;
  end

endmodule

// File: rtl/nios2_port_gpio.sv
// Zero-wait-state Avalon-MM PIO: per-bit direction, set/clear, edge capture with masked IRQ, LED blink.
// Reads are combinational; writes take effect on the next clk edge; the slave never stalls.
module nios2_port_gpio
  import nios2_port_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter logic [WIDTH-1:0] DIR_RESET   = '1,
  parameter int               EDGE_TYPE   = EDGE_RISE,
  parameter int               SYNC_STAGES = 2,
  parameter int               PRESC_W     = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic [WIDTH-1:0]   data_out;
  logic [WIDTH-1:0]   dir;
  logic [WIDTH-1:0]   irqmask;
  logic [WIDTH-1:0]   edgecap;
  logic [WIDTH-1:0]   blinken;
  logic [PRESC_W-1:0] period;
  logic [PRESC_W-1:0] presc;
  logic               phase;

  logic [WIDTH-1:0]   in_sync;
  logic [WIDTH-1:0]   edge_hit;
  logic [WIDTH-1:0]   wd;
  logic [PRESC_W-1:0] wd_period;
  logic [WIDTH-1:0]   clr;
  logic               wr;
  logic               unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign wd_period = writedata[PRESC_W-1:0];
  assign unused_wd = ^writedata;
  assign clr       = (wr && address == ADDR_EDGECAP) ? wd : '0;

  nios2_port_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .dir     (dir),
    .in_sync (in_sync),
    .edge_hit(edge_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= OUT_RESET;
      dir      <= DIR_RESET;
      irqmask  <= '0;
      blinken  <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:    data_out <= wd;
        ADDR_DIR:     dir      <= wd;
        ADDR_IRQMASK: irqmask  <= wd;
        ADDR_OUTSET:  data_out <= data_out | wd;
        ADDR_OUTCLR:  data_out <= data_out & ~wd;
        ADDR_BLINKEN: blinken  <= wd;
        default: ;
      endcase
    end
  end

  // A new edge in the same cycle as its clear leaves the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edgecap <= '0;
    else          edgecap <= (edgecap & ~clr) | edge_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period <= '0;
      presc  <= '0;
      phase  <= 1'b0;
    end else if (wr && address == ADDR_PERIOD) begin
      period <= wd_period;
      presc  <= wd_period;
      phase  <= 1'b0;
    end else if (period == '0) begin
      presc <= '0;
      phase <= 1'b0;
    end else if (presc == '0) begin
      presc <= period;
      phase <= ~phase;
    end else begin
      presc <= presc - PRESC_W'(1);
    end
  end

  assign out_port = data_out ^ (blinken & {WIDTH{phase}});
  assign oe       = dir;
  assign irq      = |(edgecap & irqmask);

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0]   = (dir & data_out) | (~dir & in_sync);
      ADDR_DIR:     readdata[WIDTH-1:0]   = dir;
      ADDR_IRQMASK: readdata[WIDTH-1:0]   = irqmask;
      ADDR_EDGECAP: readdata[WIDTH-1:0]   = edgecap;
      ADDR_BLINKEN: readdata[WIDTH-1:0]   = blinken;
      ADDR_PERIOD:  readdata[PRESC_W-1:0] = period;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nios2_port_gpio.sv
// Directed + randomized bench for nios2_port_gpio against a cycle-level register/pin-history model.
module tb_nios2_port_gpio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic [7:0]  oe;
  logic        irq;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  nios2_port_gpio #(
    .WIDTH      (8),
    .OUT_RESET  (8'hA5),
    .DIR_RESET  (8'hFF),
    .EDGE_TYPE  (0),
    .SYNC_STAGES(2),
    .PRESC_W    (24)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .oe        (oe),
    .irq       (irq)
  );

  // Reference model: register contents, pin history (one entry per clock edge),
  // and edges elapsed since the last PERIOD write for the blink phase.
  logic [7:0]  m_data, m_dir, m_mask, m_ecap, m_blinken;
  logic [23:0] m_period;
  int          m_since;
  logic [7:0]  hist[$];

  task automatic model_reset();
    m_data = 8'hA5; m_dir = 8'hFF; m_mask = 8'h00; m_ecap = 8'h00;
    m_blinken = 8'h00; m_period = 24'h0; m_since = 0;
    hist.delete();
    for (int i = 0; i < 4; i++) hist.push_back(8'h00);
  endtask

  function automatic logic [7:0] m_in_sync();
    return hist[$-1];
  endfunction

  function automatic logic m_phase();
    if (m_period == 0) return 1'b0;
    return ((m_since / (int'(m_period) + 1)) % 2) == 1;
  endfunction

  function automatic logic [7:0] exp_out();
    return m_data ^ (m_blinken & {8{m_phase()}});
  endfunction

  function automatic logic [31:0] exp_rd(input logic [2:0] a);
    case (a)
      3'd0: return {24'h0, (m_dir & m_data) | (~m_dir & m_in_sync())};
      3'd1: return {24'h0, m_dir};
      3'd2: return {24'h0, m_mask};
      3'd3: return {24'h0, m_ecap};
      3'd6: return {24'h0, m_blinken};
      3'd7: return {8'h0, m_period};
      default: return 32'h0;
    endcase
  endfunction

  // Applied at each rising edge with the bus/pin values the DUT just sampled.
  task automatic model_update();
    logic [7:0] e, clr, wd;
    e   = hist[$-1] & ~hist[$-2] & ~m_dir;
    clr = 8'h00;
    wd  = writedata[7:0];
    hist.push_back(in_port);
    if (hist.size() > 8) void'(hist.pop_front());
    m_since++;
    if (chipselect && !write_n) begin
      case (address)
        3'd0: m_data = wd;
        3'd1: m_dir = wd;
        3'd2: m_mask = wd;
        3'd3: clr = wd;
        3'd4: m_data = m_data | wd;
        3'd5: m_data = m_data & ~wd;
        3'd6: m_blinken = wd;
        default: begin m_period = writedata[23:0]; m_since = 0; end
      endcase
    end
    m_ecap = (m_ecap & ~clr) | e;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic check_outs();
    chk("out_port", {24'h0, out_port}, {24'h0, exp_out()});
    chk("oe", {24'h0, oe}, {24'h0, m_dir});
    chk("irq", {31'h0, irq}, {31'h0, |(m_ecap & m_mask)});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    cycle();
  endtask

  task automatic rd_check(input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    chk($sformatf("readdata@%0d", a), readdata, exp_rd(a));
    chipselect = 1'b0;
  endtask

  initial begin
    logic [2:0]  a;
    logic [31:0] d;

    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'h0; in_port = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_port", {24'h0, out_port}, 32'hA5);
    chk("rst_oe", {24'h0, oe}, 32'hFF);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    address = 3'd0; #1;
    chk("rst_rd_data", readdata, 32'h000000A5);
    @(negedge clk);
    reset_n = 1'b1;

    // Set / clear
    wr(3'd0, 32'hFFFF_FF0F);
    wr(3'd4, 32'h0000_0030);
    wr(3'd5, 32'h0000_0003);
    chk("setclr_out", {24'h0, out_port}, 32'h3C);
    rd_check(3'd4);
    chk("rd_outset_zero", readdata, 32'h0);
    rd_check(3'd5);
    chk("rd_outclr_zero", readdata, 32'h0);
    rd_check(3'd0);

    // Edge capture latency, W1C, falling edge ignored
    wr(3'd1, 32'hF0);
    wr(3'd2, 32'h01);
    in_port = 8'h01;
    idle(2);
    chk("irq_lat2", {31'h0, irq}, 32'h0);
    idle(1);
    chk("irq_lat3", {31'h0, irq}, 32'h1);
    rd_check(3'd3);
    chk("ecap_lat3", readdata, 32'h01);
    wr(3'd3, 32'h01);
    chk("irq_w1c", {31'h0, irq}, 32'h0);
    in_port = 8'h00;
    idle(5);
    rd_check(3'd3);
    chk("ecap_fall", readdata, 32'h0);
    rd_check(3'd0);

    // Clear coinciding with a new rising edge
    in_port = 8'h01;
    idle(2);
    wr(3'd3, 32'h01);
    rd_check(3'd3);
    chk("ecap_set_wins", readdata, 32'h01);

    // Blink
    wr(3'd0, 32'h00);
    wr(3'd6, 32'h81);
    wr(3'd7, 32'h03);
    chk("blink_p0", {24'h0, out_port}, 32'h00);
    idle(3);
    chk("blink_p0_end", {24'h0, out_port}, 32'h00);
    idle(1);
    chk("blink_p1", {24'h0, out_port}, 32'h81);
    idle(4);
    chk("blink_p2", {24'h0, out_port}, 32'h00);
    idle(2);
    wr(3'd7, 32'h00);
    chk("blink_stop", {24'h0, out_port}, 32'h00);
    idle(6);
    rd_check(3'd7);

    // Async reset mid-blink with captured edges
    wr(3'd7, 32'h02);
    in_port = 8'h0F;
    idle(5);
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_out_port", {24'h0, out_port}, 32'hA5);
    chk("arst_oe", {24'h0, oe}, 32'hFF);
    chk("arst_irq", {31'h0, irq}, 32'h0);
    rd_check(3'd3);
    chk("arst_ecap", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        a = 3'($urandom);
        d = $urandom;
        if (a == 3'd7) d = (d & 32'hFF00_0000) | 32'($urandom_range(0, 5));
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      end
      cycle();
      rd_check(3'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
